ex_fsm_piso: RTL and testbench
==============================

# ex_fsm_piso

LSB-first parallel-to-serial shifter that feeds the serial sequence-detector stage. It accepts DW-bit words over a valid/ready handshake and presents one bit per enabled clock on `sout`, with no gap between back-to-back words. With `bit_en` tied high it drives the detector's `cin` at one bit per `sclk` cycle. A configurable idle level is driven between words.

## Interface
Parameters:
- `DW`, default 8: word width; legal range DW >= 2.
- `IDLE_BIT`, default 1'b1: value on `sout` when no word is being shifted.

Ports:
- `sclk`, input, 1: clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous active-high reset, sampled on the `sclk` rising edge. One clock; reset is synchronous and active-high.
- `din`, input, DW: parallel word; bit 0 is sent first.
- `din_vld`, input, 1: `din` is valid.
- `din_rdy`, output, 1: block accepts `din` this cycle (combinational).
- `bit_en`, input, 1: bit-rate enable; the current bit is consumed on an edge where `bit_en` = 1.
- `sout`, output, 1: serial data; connects to the detector's `cin`.
- `sout_vld`, output, 1: `sout` carries a data bit.
- `busy`, output, 1: a word is in flight (equals `sout_vld`).
- `word_done`, output, 1: registered one-cycle pulse after the last bit of a word is consumed.

## Operation
- States:
  - IDLE: no word held.
  - SHIFT: a word is held in the DW-bit `shreg`; `bit_cnt` (width clog2(DW)) counts consumed bits.
- Accept rule: a word is accepted on an edge where `din_vld & din_rdy` = 1.
- `din_rdy`:
  - IDLE: 1.
  - SHIFT: `(bit_cnt == DW-1) & bit_en`, so a new word can replace the last bit seamlessly.
  - Otherwise 0.
- IDLE:
  - On accept: `shreg <= din`, `bit_cnt <= 0`, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT with `bit_en` = 0: hold all state; `sout` is stable.
- SHIFT with `bit_en` = 1 and `bit_cnt < DW-1`: `shreg <= shreg >> 1`, `bit_cnt <= bit_cnt + 1`.
- SHIFT with `bit_en` = 1 and `bit_cnt == DW-1` (last bit):
  - Set `word_done` next cycle.
  - If `din_vld` = 1: load the new word, `bit_cnt <= 0`, stay in SHIFT.
  - Else go to IDLE.
- Outputs:
  - `sout` = `shreg[0]` in SHIFT, `IDLE_BIT` in IDLE.
  - `sout_vld` = `busy` = (state == SHIFT).
  - All outputs except `din_rdy` are functions of registers only.
- `din_vld` while SHIFT and not on the last bit: not accepted, not dropped. The upstream source holds `din`/`din_vld` until `din_rdy`.
- Undefined state encoding: go to IDLE on the next edge.

## Timing
- Reset values: state IDLE, `shreg` = 0, `bit_cnt` = 0, `sout` = `IDLE_BIT`, `sout_vld` = 0, `busy` = 0, `word_done` = 0, `din_rdy` = 1 (once `rst` is low).
- Reset dominates everything, including an accept in the same cycle.
- Reset mid-word: the word is discarded; from the cycle after the reset edge the outputs take their reset values. The next accepted word starts at bit 0.
- Latency: word accepted at edge T gives bit 0 on `sout` in cycle T+1.
- With `bit_en` = 1 continuously: bit i appears in cycle T+1+i. The last bit appears in T+DW, `word_done` is high in T+DW+1, and `sout` returns to `IDLE_BIT` in T+DW+1 unless a new word was accepted.
- Back-to-back: a new word accepted on the last-bit edge puts its bit 0 in the very next cycle. `sout_vld` stays high, with no idle bit between words.
- `bit_en` throttled: each bit is held until the edge where `bit_en` = 1. `word_done` remains one cycle wide.
- `din_rdy` depends combinationally on `bit_en` and must not be registered.

## Test plan
- Reset: assert `rst` for 2 cycles with `din_vld` = 1 → no accept; `sout` = 1, `sout_vld` = 0, `word_done` = 0; `din_rdy` = 1 after release.
- Single word: DW = 8, `din` = 8'h12, `bit_en` = 1, accept at T → `sout` in T+1..T+8 = 0,1,0,0,1,0,0,0; `word_done` high only in T+9; `sout` = 1 in T+9. A chained detector flags the 10010 pattern.
- Back-to-back: `din_vld` held with 8'hA5 then 8'h3C → 16 consecutive cycles with `sout_vld` = 1, bits 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; `din_rdy` high only at T and on the last-bit cycle; `word_done` pulses at T+9 and T+17.
- Throttle: `bit_en` high 1 cycle in 3, `din` = 8'h81 → each bit held 3 cycles; 24 cycles of `sout_vld` = 1; `word_done` is a single one-cycle pulse.
- Reset mid-word: assert `rst` after 3 bits consumed → `sout_vld` = 0 and `sout` = 1 the next cycle; a following word 8'h01 starts with bit 1 then seven 0s.
- Stall: `din_vld` raised at bit 2 with `bit_en` = 1 → not accepted until the last-bit cycle; the word is then sent intact with no gap.

Source files
------------

// File: rtl/ex_fsm_piso.sv
// LSB-first parallel-to-serial shifter with a valid/ready word input and a bit-rate enable.
// Words chain with no idle bit between them when the next word is offered on the last-bit edge.
module ex_fsm_piso #(
    parameter int   DW       = 8,
    parameter logic IDLE_BIT = 1'b1
) (
    input  logic          sclk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          din_vld,
    output logic          din_rdy,
    input  logic          bit_en,
    output logic          sout,
    output logic          sout_vld,
    output logic          busy,
    output logic          word_done,
    output logic [1:0]    dbg_state
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] shreg_q, shreg_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic          sout_q, sout_vld_q, word_done_q;
    logic          word_done_d;
    logic          last_bit;

    // Handshake: a word is taken on any edge where din_vld & din_rdy. The source
    // holds din/din_vld until then; din_rdy is combinational so a new word can
    // replace the last bit on the very edge that consumes it.
    assign last_bit = (bit_cnt_q == CW'(DW - 1));
    assign din_rdy  = (state_q == ST_IDLE) || ((state_q == ST_SHIFT) && last_bit && bit_en);

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        word_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (din_vld) begin
                    shreg_d   = din;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_en) begin
                    if (!last_bit) begin
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else begin
                        word_done_d = 1'b1;
                        if (din_vld) begin
                            shreg_d   = din;
                            bit_cnt_d = '0;
                        end else begin
                            shreg_d   = shreg_q >> 1;
                            bit_cnt_d = '0;
                            state_d   = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                shreg_d   = '0;
                bit_cnt_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with state_q.
    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            sout_q      <= IDLE_BIT;
            sout_vld_q  <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            sout_q      <= (state_d == ST_SHIFT) ? shreg_d[0] : IDLE_BIT;
            sout_vld_q  <= (state_d == ST_SHIFT);
            word_done_q <= word_done_d;
        end
    end

    assign sout      = sout_q;
    assign sout_vld  = sout_vld_q;
    assign busy      = sout_vld_q;
    assign word_done = word_done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ex_fsm_piso.sv
// Directed bench for ex_fsm_piso (DW=8, IDLE_BIT=1): reset, single word,
// back-to-back, throttled enable, reset mid-word and stalled second word.
module tb_ex_fsm_piso;

    logic       sclk;
    logic       rst;
    logic [7:0] din;
    logic       din_vld;
    logic       din_rdy;
    logic       bit_en;
    logic       sout;
    logic       sout_vld;
    logic       busy;
    logic       word_done;
    logic [1:0] dbg_state;

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0] stream;

    ex_fsm_piso #(.DW(8), .IDLE_BIT(1'b1)) dut (
        .sclk      (sclk),
        .rst       (rst),
        .din       (din),
        .din_vld   (din_vld),
        .din_rdy   (din_rdy),
        .bit_en    (bit_en),
        .sout      (sout),
        .sout_vld  (sout_vld),
        .busy      (busy),
        .word_done (word_done),
        .dbg_state (dbg_state)
    );

    // clock
    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // advance one edge, then settle 1 time unit so outputs are stable for checking
    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_sout"}, sout, 1'b1);
        chk({tag, "_vld"},  sout_vld, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        rst     = 1'b1;
        din     = 8'hFF;
        din_vld = 1'b1;
        bit_en  = 1'b1;

        // Reset with din_vld high: nothing may be accepted
        tick();
        tick();
        chk_idle("rst");
        chk("rst_done", word_done, 1'b0);
        chk("rst_state", dbg_state, 2'b00);
        rst     = 1'b0;
        din_vld = 1'b0;
        #1;
        chk("rst_rdy", din_rdy, 1'b1);
        tick();
        chk_idle("post_rst");

        // Single word 8'h12 -> 0,1,0,0,1,0,0,0
        din     = 8'h12;
        din_vld = 1'b1;
        #1;
        chk("single_rdy_idle", din_rdy, 1'b1);
        tick();
        din_vld = 1'b0;
        stream  = 16'h0012;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("single_bit%0d", i), sout, stream[i]);
            chk($sformatf("single_vld%0d", i), sout_vld, 1'b1);
            chk($sformatf("single_done%0d", i), word_done, 1'b0);
            tick();
        end
        chk("single_done", word_done, 1'b1);
        chk_idle("single_end");
        tick();
        chk("single_done_clr", word_done, 1'b0);

        // Back-to-back A5 then 3C: 16 contiguous bits
        din     = 8'hA5;
        din_vld = 1'b1;
        tick();
        din    = 8'h3C;
        stream = 16'h3CA5;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("b2b_bit%0d", i), sout, stream[i]);
            chk($sformatf("b2b_vld%0d", i), sout_vld, 1'b1);
            chk($sformatf("b2b_rdy%0d", i), din_rdy, (i == 7 || i == 15) ? 1'b1 : 1'b0);
            chk($sformatf("b2b_done%0d", i), word_done, (i == 8) ? 1'b1 : 1'b0);
            tick();
            if (i == 7) din_vld = 1'b0;
        end
        chk("b2b_done2", word_done, 1'b1);
        chk_idle("b2b_end");
        tick();
        chk("b2b_done2_clr", word_done, 1'b0);

        // Throttled: bit_en high one cycle in three, word 8'h81
        din     = 8'h81;
        din_vld = 1'b1;
        bit_en  = 1'b0;
        tick();
        din_vld = 1'b0;
        stream  = 16'h0081;
        for (int c = 0; c < 24; c++) begin
            bit_en = (c % 3 == 2);
            #1;
            chk($sformatf("thr_bit%0d", c), sout, stream[c / 3]);
            chk($sformatf("thr_vld%0d", c), sout_vld, 1'b1);
            chk($sformatf("thr_done%0d", c), word_done, 1'b0);
            chk($sformatf("thr_rdy%0d", c), din_rdy, (c == 23) ? 1'b1 : 1'b0);
            tick();
        end
        bit_en = 1'b0;
        chk("thr_done", word_done, 1'b1);
        chk_idle("thr_end");
        tick();
        chk("thr_done_clr", word_done, 1'b0);
        bit_en = 1'b1;

        // Reset after 3 bits consumed, then word 8'h01 starts at bit 0
        din     = 8'hFE;
        din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_bit3", sout, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("mid_rst");
        chk("mid_rst_done", word_done, 1'b0);
        din     = 8'h01;
        din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("mid_bit%0d", i), sout, (i == 0) ? 1'b1 : 1'b0);
            chk($sformatf("mid_vld%0d", i), sout_vld, 1'b1);
            tick();
        end
        chk("mid_done", word_done, 1'b1);
        chk_idle("mid_end");
        tick();

        // Stall: second word 8'hC3 offered at bit 2 of 8'h5A
        din     = 8'h5A;
        din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        stream  = 16'hC35A;
        for (int i = 0; i < 16; i++) begin
            if (i == 2) begin
                din     = 8'hC3;
                din_vld = 1'b1;
                #1;
            end
            chk($sformatf("stall_bit%0d", i), sout, stream[i]);
            chk($sformatf("stall_vld%0d", i), sout_vld, 1'b1);
            if (i < 8) chk($sformatf("stall_rdy%0d", i), din_rdy, (i == 7) ? 1'b1 : 1'b0);
            tick();
            if (i == 7) din_vld = 1'b0;
        end
        chk("stall_done", word_done, 1'b1);
        chk_idle("stall_end");
        tick();
        chk("stall_done_clr", word_done, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
